// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: operation select codes,
// flag bit positions, skid-buffer state encoding and an op-class helper.
package alu_pkg;

  // Operation select driven alongside the arithmetic result.
  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_DIV  = 3'b010,
    OP_MUL  = 3'b011,
    OP_SUBC = 3'b100
  } op_sel_e;

  // Flag vector layout {Z,Neg,C,V}.
  localparam int FLAG_W   = 4;
  localparam int FLAG_Z   = 3;
  localparam int FLAG_NEG = 2;
  localparam int FLAG_C   = 1;
  localparam int FLAG_V   = 0;

  // Occupancy of the two-entry skid buffer.
  typedef enum logic [1:0] {
    FIFO_EMPTY = 2'b00,
    FIFO_ONE   = 2'b01,
    FIFO_TWO   = 2'b10
  } fifo_state_e;

  // How carry/overflow are derived for a given select code.
  typedef enum logic [1:0] {
    CLS_ADD  = 2'b00,
    CLS_SUB  = 2'b01,
    CLS_NONE = 2'b10
  } op_class_e;

  // Map a select code to its flag class; the unnamed codes 101/110/111
  // are add-family operations.
  function automatic op_class_e op_class(input logic [2:0] sel);
    op_class_e cls;
    case (sel)
      OP_ADD:          cls = CLS_ADD;
      OP_SUB, OP_SUBC: cls = CLS_SUB;
      OP_DIV, OP_MUL:  cls = CLS_NONE;
      default:         cls = CLS_ADD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational {Z,Neg,C,V} generation for one arithmetic result.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]      result,
  input  logic              cout,
  input  logic [2:0]        sel,
  input  logic              a_msb,
  input  logic              b_msb,
  output logic [FLAG_W-1:0] flags
);

  logic zero_s;
  logic neg_s;
  logic carry_s;
  logic ovf_s;

  // Derive flags from the result sign/zero and the operand sign bits.
  always_comb begin
    zero_s  = (result == {N{1'b0}});
    neg_s   = result[N-1];
    carry_s = 1'b0;
    ovf_s   = 1'b0;
    case (op_class(sel))
      CLS_ADD: begin
        carry_s = cout;
        ovf_s   = (a_msb == b_msb) & (result[N-1] != a_msb);
      end
      CLS_SUB: begin
        carry_s = 1'b0;
        ovf_s   = (a_msb != b_msb) & (result[N-1] != a_msb);
      end
      CLS_NONE: begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
      default: begin
        carry_s = 1'b0;
        ovf_s   = 1'b0;
      end
    endcase
    flags           = {FLAG_W{1'b0}};
    flags[FLAG_Z]   = zero_s;
    flags[FLAG_NEG] = neg_s;
    flags[FLAG_C]   = carry_s;
    flags[FLAG_V]   = ovf_s;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: captures result plus flags into a two-entry skid
// buffer with valid/ready handshakes and a saturating accept counter.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_result,
  input  logic              in_cout,
  input  logic [2:0]        in_sel,
  input  logic              in_a_msb,
  input  logic              in_b_msb,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      out_result,
  output logic [FLAG_W-1:0] out_flags,
  output logic [15:0]       out_count
);

  fifo_state_e       state_r;
  fifo_state_e       state_s;
  logic              in_ready_r;
  logic              out_valid_r;
  logic [N-1:0]      head_result_r;
  logic [FLAG_W-1:0] head_flags_r;
  logic [N-1:0]      tail_result_r;
  logic [FLAG_W-1:0] tail_flags_r;
  logic [15:0]       count_r;
  logic [FLAG_W-1:0] cap_flags_s;
  logic              push_s;
  logic              pop_s;
  logic              head_load_new_s;
  logic              head_load_tail_s;
  logic              tail_load_s;

  alu_flag_gen #(.N(N)) u_flag_gen (
    .result (in_result),
    .cout   (in_cout),
    .sel    (in_sel),
    .a_msb  (in_a_msb),
    .b_msb  (in_b_msb),
    .flags  (cap_flags_s)
  );

  // Handshakes qualify only on registered ready/valid, so upstream data
  // is ignored whenever this stage is not accepting.
  assign push_s = in_valid & in_ready_r;
  assign pop_s  = out_valid_r & out_ready;

  // Next occupancy and which storage slot gets loaded this cycle.
  always_comb begin
    state_s          = state_r;
    head_load_new_s  = 1'b0;
    head_load_tail_s = 1'b0;
    tail_load_s      = 1'b0;
    case (state_r)
      FIFO_EMPTY: begin
        if (push_s) begin
          state_s         = FIFO_ONE;
          head_load_new_s = 1'b1;
        end else begin
          state_s = FIFO_EMPTY;
        end
      end
      FIFO_ONE: begin
        if (push_s && pop_s) begin
          // Head leaves and the new entry takes its place directly.
          state_s         = FIFO_ONE;
          head_load_new_s = 1'b1;
        end else if (push_s) begin
          state_s     = FIFO_TWO;
          tail_load_s = 1'b1;
        end else if (pop_s) begin
          state_s = FIFO_EMPTY;
        end else begin
          state_s = FIFO_ONE;
        end
      end
      FIFO_TWO: begin
        // No push is possible here because in_ready is low.
        if (pop_s) begin
          state_s          = FIFO_ONE;
          head_load_tail_s = 1'b1;
        end else begin
          state_s = FIFO_TWO;
        end
      end
      default: begin
        state_s = FIFO_EMPTY;
      end
    endcase
  end

  // Occupancy register with ready/valid decoded one cycle ahead so both
  // handshake outputs come straight from flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= FIFO_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s != FIFO_TWO);
      out_valid_r <= (state_s != FIFO_EMPTY);
    end
  end

  // Head slot: loads a fresh capture or promotes the tail; otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_result_r <= {N{1'b0}};
      head_flags_r  <= {FLAG_W{1'b0}};
    end else if (head_load_new_s) begin
      head_result_r <= in_result;
      head_flags_r  <= cap_flags_s;
    end else if (head_load_tail_s) begin
      head_result_r <= tail_result_r;
      head_flags_r  <= tail_flags_r;
    end else begin
      head_result_r <= head_result_r;
      head_flags_r  <= head_flags_r;
    end
  end

  // Tail slot: only written when the head is occupied and not draining.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tail_result_r <= {N{1'b0}};
      tail_flags_r  <= {FLAG_W{1'b0}};
    end else if (tail_load_s) begin
      tail_result_r <= in_result;
      tail_flags_r  <= cap_flags_s;
    end else begin
      tail_result_r <= tail_result_r;
      tail_flags_r  <= tail_flags_r;
    end
  end

  // Accepted-entry counter, sticking at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'h0000;
    end else if (push_s && (count_r != 16'hFFFF)) begin
      count_r <= count_r + 16'h0001;
    end else begin
      count_r <= count_r;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_result = head_result_r;
  assign out_flags  = head_flags_r;
  assign out_count  = count_r;

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: a driver pushes reference-model
// expectations on each accepted input; a monitor pops and compares on
// each output handshake.
`timescale 1ns/1ps
module tb_alu_result_stage;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_result;
  logic         in_cout;
  logic [2:0]   in_sel;
  logic         in_a_msb;
  logic         in_b_msb;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_result;
  logic [3:0]   out_flags;
  logic [15:0]  out_count;

  typedef struct packed {
    logic [7:0] res;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cmp_cnt   = 0;
  int   fail_cnt  = 0;
  int   model_cnt = 0;
  bit   rnd_rdy   = 1'b0;

  alu_result_stage #(.N(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_cout    (in_cout),
    .in_sel     (in_sel),
    .in_a_msb   (in_a_msb),
    .in_b_msb   (in_b_msb),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags),
    .out_count  (out_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    cmp_cnt++;
    if (act !== exp_v) begin
      fail_cnt++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Reference: operands -> upstream result/carry and the flags a correct
  // stage must report, using signed integer arithmetic for overflow.
  function automatic void ref_model(input logic [7:0] a, input logic [7:0] b,
                                    input logic [2:0] sel, input logic [7:0] alt,
                                    output logic [7:0] res, output logic co,
                                    output logic [3:0] flags);
    int sa, sb, full, sgn;
    logic c, v;
    sa = a[7] ? int'(a) - 256 : int'(a);
    sb = b[7] ? int'(b) - 256 : int'(b);
    if (sel == 3'd1 || sel == 3'd4) begin
      full = int'(a) - int'(b);
      res  = 8'(full);
      co   = alt[0];
      sgn  = sa - sb;
      c    = 1'b0;
      v    = (sgn > 127) || (sgn < -128);
    end else if (sel == 3'd2 || sel == 3'd3) begin
      res = alt;
      co  = alt[1];
      c   = 1'b0;
      v   = 1'b0;
    end else begin
      full = int'(a) + int'(b);
      res  = 8'(full);
      co   = (full > 255);
      sgn  = sa + sb;
      c    = co;
      v    = (sgn > 127) || (sgn < -128);
    end
    flags = {(res == 8'd0), res[7], c, v};
  endfunction

  // Offer one operation; record the expectation at the cycle it is accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                      input logic [7:0] alt, output int waited);
    logic [7:0] res;
    logic       co;
    logic [3:0] fl;
    bit         done;
    ref_model(a, b, sel, alt, res, co, fl);
    in_result = res;
    in_cout   = co;
    in_sel    = sel;
    in_a_msb  = a[7];
    in_b_msb  = b[7];
    in_valid  = 1'b1;
    done      = 1'b0;
    waited    = 0;
    while (!done && waited < 64) begin
      @(negedge clk);
      if (in_ready) begin
        check("count_before_push", 32'(out_count), 32'(model_cnt));
        exp_q.push_back(exp_t'({res, fl}));
        if (model_cnt < 65535) model_cnt++;
        done = 1'b1;
      end else begin
        waited++;
      end
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    in_result = 8'($urandom);
    in_cout   = 1'($urandom);
    if (!done) begin
      cmp_cnt++;
      fail_cnt++;
      $display("FAIL send_timeout: input not accepted within 64 cycles (t=%0t)", $time);
    end
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] v;
    case ($urandom_range(0, 4))
      0:       v = 8'h00;
      1:       v = 8'h7F;
      2:       v = 8'h80;
      3:       v = 8'hFF;
      default: v = 8'($urandom);
    endcase
    return v;
  endfunction

  // Output monitor: every head handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        cmp_cnt++;
        fail_cnt++;
        $display("FAIL pop_unexpected: got result %0h with nothing expected (t=%0t)", out_result, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_result", 32'(out_result), 32'(mon_e.res));
        check("out_flags", 32'(out_flags), 32'(mon_e.flags));
      end
    end
  end

  // Random downstream back-pressure during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = 8'h00;
    in_cout   = 1'b0;
    in_sel    = 3'd0;
    in_a_msb  = 1'b0;
    in_b_msb  = 1'b0;
    out_ready = 1'b0;
    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_result", 32'(out_result), 32'd0);
    check("rst_out_flags", 32'(out_flags), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Add overflow, accepted on the first edge out of reset, visible next cycle.
    send(8'h7F, 8'h01, 3'b000, 8'h00, w);
    check("first_push_wait", 32'(w), 32'd0);
    check("latency_valid", 32'(out_valid), 32'd1);
    check("add_ovf_result", 32'(out_result), 32'h80);
    check("add_ovf_flags", 32'(out_flags), 32'b0101);
    check("count_one", 32'(out_count), 32'd1);
    pop_one();
    check("empty_after_pop", 32'(out_valid), 32'd0);

    send(8'h05, 8'h05, 3'b001, 8'h01, w);
    check("sub_zero_flags", 32'(out_flags), 32'b1000);
    pop_one();
    send(8'hFF, 8'h01, 3'b000, 8'h00, w);
    check("add_carry_result", 32'(out_result), 32'h00);
    check("add_carry_flags", 32'(out_flags), 32'b1010);
    pop_one();

    // Back-pressure: two accepted, third held upstream, then in-order drain.
    send(8'h11, 8'h22, 3'b000, 8'h00, w);
    send(8'h33, 8'h44, 3'b001, 8'h00, w);
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_valid  = 1'b1;
    in_result = 8'hA5;
    in_sel    = 3'b011;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_head_result", 32'(out_result), 32'h33);
      check("hold_head_flags", 32'(out_flags), 32'b0000);
    end
    out_ready = 1'b1;
    send(8'h55, 8'h66, 3'b011, 8'h99, w);
    check("third_wait", 32'(w), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("bp_drained", 32'(exp_q.size()), 32'd0);
    check("bp_idle_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset with both entries occupied.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 3'b000, 8'h00, w);
    send(8'h03, 8'h04, 3'b000, 8'h00, w);
    #3;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_count", 32'(out_count), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_flags", 32'(out_flags), 32'd0);
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming in ONE: push and pop every cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), w);
      check("stream_wait", 32'(w), 32'd0);
    end
    check("stream_count", 32'(out_count), 32'd11);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("stream_drained", 32'(exp_q.size()), 32'd0);
    check("stream_idle_valid", 32'(out_valid), 32'd0);

    // Random traffic with random back-pressure and idle gaps.
    rnd_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      send(pick_operand(), pick_operand(), 3'($urandom_range(0, 7)), 8'($urandom), w);
    end
    rnd_rdy   = 1'b0;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("random_drained", 32'(exp_q.size()), 32'd0);

    // Counter saturation.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65540; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 8'($urandom), w);
    end
    check("count_saturated", 32'(out_count), 32'h0000FFFF);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("sat_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter N SHALL default to 8 and set the operand/result width.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 in_valid  in  1  upstream arithmetic result present.
REQ-005 in_ready  out  1  stage can accept an entry this cycle.
REQ-006 in_result  in  N  arithmetic mux output.
REQ-007 in_cout  in  1  adder carry-out.
REQ-008 in_sel  in  3  operation select that produced in_result.
REQ-009 in_a_msb, in_b_msb  in  1 each  sign bits of operands A and B.
REQ-010 out_valid  out  1  head entry available.
REQ-011 out_ready  in  1  downstream accepts head entry.
REQ-012 out_result  out  N  head result.
REQ-013 out_flags  out  4  head flags {Z,Neg,C,V}, bit3..bit0.
REQ-014 out_count  out  16  accepted-result counter.

Function
REQ-015 Flags SHALL be computed combinationally from inputs at capture, then stored with the result.
REQ-016 Z SHALL be 1 iff in_result == 0; Neg SHALL equal in_result[N-1].
REQ-017 Add codes (000,101,110,111): C = in_cout; V = (a_msb==b_msb) & (result msb != a_msb).
REQ-018 Subtract codes (001,100): C = 0; V = (a_msb!=b_msb) & (result msb != a_msb).
REQ-019 Codes 010,011: C = 0, V = 0.
REQ-020 Storage SHALL be a 2-entry FIFO (skid buffer) with states EMPTY, ONE, TWO.
REQ-021 Push occurs when in_valid & in_ready; pop when out_valid & out_ready.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, driven from registered state only.
REQ-023 out_valid SHALL be 1 in ONE and TWO; out_result/out_flags SHALL show the oldest entry.
REQ-024 Latency: input pushed in cycle t SHALL appear at out_valid in cycle t+1 when FIFO was EMPTY.
REQ-025 Transitions: EMPTY-push->ONE; ONE-push only->TWO; ONE-pop only->EMPTY; ONE-push&pop->ONE; TWO-pop->ONE.
REQ-026 Simultaneous push and pop in ONE SHALL replace the head with the new entry, no loss, no duplicate.
REQ-027 Head data SHALL remain stable while out_valid=1 and out_ready=0.
REQ-028 out_count SHALL increment by 1 on each push and saturate at 16'hFFFF.
REQ-029 in_* data SHALL be ignored when in_valid=0 or in_ready=0.

Reset
REQ-030 rst=1 SHALL immediately force state EMPTY, out_valid=0, out_count=0, out_result=0, out_flags=0.
REQ-031 in_ready SHALL be 1 during and after reset; entries in flight at reset SHALL be discarded.
REQ-032 First push SHALL be accepted on the first rising edge with rst=0.

Structure
REQ-033 Shared package alu_pkg SHALL hold the op-select enum (ADD=000, SUB=001, DIV=010, MUL=011, SUBC=100), flag bit index constants, and FIFO state enum.
REQ-034 Flag computation SHALL be a sub-module alu_flag_gen (combinational, parameter N).

Verification (N=8)
REQ-035 Add 0x7F+0x01, sel=000, cout=0 -> next cycle out_result=0x80, flags Z0 Neg1 C0 V1.
REQ-036 Sub 0x05-0x05 result 0x00, sel=001 -> flags Z1 Neg0 C0 V0; add 0xFF+0x01 result 0x00 cout=1 -> Z1 C1 V0.
REQ-037 out_ready=0, push 3 entries back-to-back -> two accepted, in_ready=0 after second, third held upstream; release out_ready -> both pop in order.
REQ-038 ONE state, push and pop same cycle for 10 cycles -> each result out exactly once, in order, out_count=11.
REQ-039 Assert rst mid-stream with TWO full -> out_valid drops same cycle without clock edge, out_count=0, in_ready=1.
REQ-040 Force 65536+ pushes -> out_count holds 0xFFFF.
